synch_bin_down_timer: RTL and testbench

- Synchronous, loadable binary down-counter/timer; the counting-down counterpart of the team's up-counter.
- Loads a start value, decrements once per enabled clock, and flags terminal count with a one-cycle pulse.
- Supports one-shot or auto-reload (periodic) operation.
- Used as a programmable delay or tick generator next to the up-counter blocks.

---
 rtl/synch_bin_down_timer.sv | 144 ++++++++++++++
 tb/tb_synch_bin_down_timer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/synch_bin_down_timer.sv
`default_nettype none
// ============================================================================
// Module   : synch_bin_down_timer
// Purpose  : Loadable binary down-counter / timer. A nonzero load value starts
//            a countdown. The count drops by one on each enabled tick, and a
//            one-cycle terminal-count pulse marks expiry. In one-shot mode the
//            block then parks in DONE. In auto-reload mode it restarts from
//            the last loaded value, which gives a period of N ticks for load N.
// Options  : DOWNCNT_PRESCALE_EN - when defined, a tick is Pdiv enabled
//            cycles instead of one enabled cycle.
// Ports    : clk         in   clock, rising edge
//            rst         in   asynchronous reset, active low
//            ena         in   count enable (ignored in IDLE and DONE)
//            load        in   synchronous load strobe, has priority over ena
//            load_val    in   [Dwidth] start value captured on load
//            auto_reload in   1 = periodic, 0 = one-shot (sampled at expiry)
//            counter     out  [Dwidth] current count, registered
//            tc          out  terminal-count pulse, registered, one cycle
//            busy        out  state == RUN
//            done        out  state == DONE
// Revision : 1.0 - initial release
// ============================================================================
module synch_bin_down_timer #(
    parameter int Dwidth = 4,
    parameter int Pdiv   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              load,
    input  logic [Dwidth-1:0] load_val,
    input  logic              auto_reload,
    output logic [Dwidth-1:0] counter,
    output logic              tc,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // An out-of-range prescale ratio freezes the count. This makes a bad
    // parameter obvious instead of producing a wrong tick rate.
    localparam logic c_PDIV_LEGAL = (Pdiv >= 2) && (Pdiv <= 256);

    state_t            state_q,   state_d;
    logic [Dwidth-1:0] counter_q, counter_d;
    logic [Dwidth-1:0] reload_q,  reload_d;
    logic              tc_q,      tc_d;
    logic              w_tick;

`ifdef DOWNCNT_PRESCALE_EN
    localparam int                  c_PRESCALE_W = (Pdiv > 2) ? $clog2(Pdiv) : 1;
    localparam logic [c_PRESCALE_W-1:0] c_PRESCALE_LAST = c_PRESCALE_W'(Pdiv - 1);

    logic [c_PRESCALE_W-1:0] prescale_q, prescale_d;

    // The prescaler advances only on enabled RUN cycles. Its wrap is the tick.
    always_comb begin
        prescale_d = prescale_q;
        w_tick     = 1'b0;
        if (load) begin
            prescale_d = '0;
        end else if ((state_q == ST_RUN) && ena && c_PDIV_LEGAL) begin
            if (prescale_q == c_PRESCALE_LAST) begin
                prescale_d = '0;
                w_tick     = 1'b1;
            end else begin
                prescale_d = prescale_q + c_PRESCALE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescale_q <= '0;
        end else begin
            prescale_q <= prescale_d;
        end
    end
`else
    // Without the prescaler, every enabled cycle is a tick.
    always_comb begin
        w_tick = ena && c_PDIV_LEGAL;
    end
`endif

    // Next-state and datapath logic
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        reload_d  = reload_q;
        tc_d      = 1'b0;

        if (load) begin
            if (load_val != '0) begin
                counter_d = load_val;
                reload_d  = load_val;
                state_d   = ST_RUN;
            end else begin
                counter_d = '0;
                state_d   = ST_IDLE;
            end
        end else if ((state_q == ST_RUN) && w_tick) begin
            if (counter_q > Dwidth'(1)) begin
                counter_d = counter_q - Dwidth'(1);
            end else if (counter_q == Dwidth'(1)) begin
                tc_d = 1'b1;
                if (auto_reload) begin
                    // Jump straight to the reload value so that 0 is never
                    // shown. This keeps the period at exactly N ticks.
                    counter_d = reload_q;
                end else begin
                    counter_d = '0;
                    state_d   = ST_DONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            counter_q <= '0;
            reload_q  <= '0;
            tc_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            reload_q  <= reload_d;
            tc_q      <= tc_d;
        end
    end

    assign counter = counter_q;
    assign tc      = tc_q;
    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_synch_bin_down_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_synch_bin_down_timer
// Purpose  : Directed self-checking bench for synch_bin_down_timer. Expected
//            values are hand-computed. Inputs change 1 ns after the rising
//            edge, and outputs are checked at that same point.
// Revision : 1.0 - initial release
// ============================================================================
module tb_synch_bin_down_timer;

    localparam int c_DW = 4;

    logic            clk;
    logic            rst;
    logic            ena;
    logic            load;
    logic [c_DW-1:0] load_val;
    logic            auto_reload;
    logic [c_DW-1:0] counter;
    logic            tc;
    logic            busy;
    logic            done;

    int n_checks;
    int n_fails;

    synch_bin_down_timer #(
        .Dwidth (c_DW),
        .Pdiv   (4)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .load        (load),
        .load_val    (load_val),
        .auto_reload (auto_reload),
        .counter     (counter),
        .tc          (tc),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int c, input bit t, input bit b, input bit d);
        check({tag, ".counter"}, 32'(counter), 32'(c));
        check({tag, ".tc"},      32'(tc),      32'(t));
        check({tag, ".busy"},    32'(busy),    32'(b));
        check({tag, ".done"},    32'(done),    32'(d));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int v);
        load     = 1'b1;
        load_val = c_DW'(v);
        tick();
        load     = 1'b0;
    endtask

    initial begin
        int exp_ar [9];
        bit ena_pat [7];
        int exp_g [7];

        n_checks    = 0;
        n_fails     = 0;
        rst         = 1'b0;
        ena         = 1'b0;
        load        = 1'b0;
        load_val    = '0;
        auto_reload = 1'b0;
        tick();
        expect_out("por", 0, 0, 0, 0);
        rst = 1'b1;
        tick();

        // Asynchronous reset while load is held with a nonzero value
        load = 1'b1; load_val = 4'd9; ena = 1'b1;
        tick();
        expect_out("rst_pre", 9, 0, 1, 0);
        #2 rst = 1'b0;
        #1 expect_out("rst_async", 0, 0, 0, 0);
        #1 rst = 1'b1;
        load = 1'b0;
        tick();
        expect_out("rst_idle1", 0, 0, 0, 0);
        tick();
        expect_out("rst_idle2", 0, 0, 0, 0);

`ifdef DOWNCNT_PRESCALE_EN
        // Prescaled countdown, Pdiv=4: one count step every 4 enabled cycles
        auto_reload = 1'b0;
        ena         = 1'b1;
        do_load(2);
        expect_out("ps_load", 2, 0, 1, 0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i < 4)       expect_out($sformatf("ps_c%0d", i), 2, 0, 1, 0);
            else if (i < 8)  expect_out($sformatf("ps_c%0d", i), 1, 0, 1, 0);
            else             expect_out($sformatf("ps_c%0d", i), 0, 1, 0, 1);
        end
        tick();
        expect_out("ps_after", 0, 0, 0, 1);
`else
        // One-shot from 5
        auto_reload = 1'b0;
        ena         = 1'b1;
        do_load(5);
        expect_out("os_load", 5, 0, 1, 0);
        for (int v = 4; v >= 1; v--) begin
            tick();
            expect_out($sformatf("os_%0d", v), v, 0, 1, 0);
        end
        tick();
        expect_out("os_tc", 0, 1, 0, 1);
        tick();
        expect_out("os_hold1", 0, 0, 0, 1);
        tick();
        expect_out("os_hold2", 0, 0, 0, 1);

        // Auto-reload from 3
        auto_reload = 1'b1;
        do_load(3);
        expect_out("ar_load", 3, 0, 1, 0);
        exp_ar = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
        for (int i = 0; i < 9; i++) begin
            tick();
            expect_out($sformatf("ar_%0d", i), exp_ar[i], exp_ar[i] == 3, 1, 0);
        end

        // Gated enable from 4
        auto_reload = 1'b0;
        do_load(4);
        expect_out("ge_load", 4, 0, 1, 0);
        ena_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        exp_g   = '{3, 3, 3, 2, 1, 1, 0};
        for (int i = 0; i < 7; i++) begin
            ena = ena_pat[i];
            tick();
            expect_out($sformatf("ge_%0d", i), exp_g[i], i == 6, i != 6, i == 6);
        end

        // Reload at count 1 while enabled: load beats terminal count
        ena = 1'b1;
        do_load(2);
        tick();
        expect_out("rl_at1", 1, 0, 1, 0);
        do_load(9);
        expect_out("rl_9", 9, 0, 1, 0);

        // Loading zero parks in IDLE with no pulse
        do_load(0);
        expect_out("lz", 0, 0, 0, 0);
        tick();
        expect_out("lz_hold", 0, 0, 0, 0);

        // Full-scale countdown from 15
        do_load(15);
        expect_out("fs_load", 15, 0, 1, 0);
        for (int v = 14; v >= 1; v--) begin
            tick();
            expect_out($sformatf("fs_%0d", v), v, 0, 1, 0);
        end
        tick();
        expect_out("fs_tc", 0, 1, 0, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
